// File: rtl/snn_enc_pkg.sv
// Shared types and constants for the image spike encoder.
// SPIKE_ENC_PHASE_INIT_EN selects a half-scale accumulator start (rounded spike counts).
package snn_enc_pkg;

    localparam int unsigned IMAGE_SIZE      = 256;
    localparam int unsigned IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE);
    localparam int unsigned PIXEL_MAX_VALUE = 255;
    localparam int unsigned PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE);
    localparam int unsigned NUM_STEPS       = 16;
    localparam int unsigned STEP_BITS       = $clog2(NUM_STEPS);

    typedef logic [PIXEL_BITS-1:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SCAN,
        STEP_END,
        DONE
    } enc_state_t;

`ifdef SPIKE_ENC_PHASE_INIT_EN
    localparam pixel_t ACC_INIT = pixel_t'(1 << (PIXEL_BITS - 1));
`else
    localparam pixel_t ACC_INIT = '0;
`endif

endpackage

// File: rtl/rate_accumulator_bank.sv
// Per-pixel image and phase-accumulator storage with a single indexed read/modify/write port.
module rate_accumulator_bank
    import snn_enc_pkg::*;
(
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  load_i,
    input  logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] image_i,
    input  logic [IMAGE_SIZE_BITS-1:0]            idx_i,
    input  logic                                  wr_en_i,
    output logic                                  carry_o
);

    pixel_t pix_q [IMAGE_SIZE];
    pixel_t pix_d [IMAGE_SIZE];
    pixel_t acc_q [IMAGE_SIZE];
    pixel_t acc_d [IMAGE_SIZE];

    logic [PIXEL_BITS:0] sum;

    assign sum     = {1'b0, acc_q[idx_i]} + {1'b0, pix_q[idx_i]};
    assign carry_o = sum[PIXEL_BITS];

    // The carry is dropped on write-back: each overflow is one emitted spike.
    always_comb begin
        pix_d = pix_q;
        acc_d = acc_q;
        if (load_i) begin
            for (int i = 0; i < IMAGE_SIZE; i++) begin
                pix_d[i] = image_i[i];
                acc_d[i] = ACC_INIT;
            end
        end else if (wr_en_i) begin
            acc_d[idx_i] = sum[PIXEL_BITS-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pix_q <= '{default: '0};
            acc_q <= '{default: '0};
        end else begin
            pix_q <= pix_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/image_spike_encoder.sv
// Rate-encodes a captured 256-pixel image into AER spike events over NUM_STEPS timesteps.
// Build option SPIKE_ENC_PHASE_INIT_EN (see snn_enc_pkg) changes the accumulator start value.
module image_spike_encoder
    import snn_enc_pkg::*;
(
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] IMAGE,
    input  logic                                  NEW_IMAGE,
    output logic                                  SPIKE_VALID,
    input  logic                                  SPIKE_READY,
    output logic [IMAGE_SIZE_BITS-1:0]            SPIKE_ADDR,
    output logic                                  TIMESTEP_DONE,
    output logic                                  ENCODE_DONE,
    output logic                                  BUSY
);

    localparam logic [IMAGE_SIZE_BITS-1:0] LastIdx  = IMAGE_SIZE_BITS'(IMAGE_SIZE - 1);
    localparam logic [STEP_BITS-1:0]       LastStep = STEP_BITS'(NUM_STEPS - 1);

    enc_state_t                 state_q, state_d;
    logic [IMAGE_SIZE_BITS-1:0] idx_q, idx_d;
    logic [STEP_BITS-1:0]       t_q, t_d;
    logic                       new_img_q;
    logic                       busy_q, busy_d;
    logic                       ts_done_q, ts_done_d;
    logic                       enc_done_q, enc_done_d;

    logic start;
    logic carry;
    logic retire;
    logic load;
    logic wr_en;

    rate_accumulator_bank u_bank (
        .clk_i   (CLK),
        .rst_i   (RST),
        .load_i  (load),
        .image_i (IMAGE),
        .idx_i   (idx_q),
        .wr_en_i (wr_en),
        .carry_o (carry)
    );

    assign start  = NEW_IMAGE & ~new_img_q;
    // A spiking pixel only retires once the core takes the event.
    assign retire = ~carry | SPIKE_READY;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        t_d     = t_q;
        load    = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                load    = 1'b1;
                idx_d   = '0;
                t_d     = '0;
                state_d = SCAN;
            end
            SCAN: begin
                if (retire) begin
                    wr_en = 1'b1;
                    idx_d = idx_q + IMAGE_SIZE_BITS'(1);
                    if (idx_q == LastIdx) state_d = STEP_END;
                end
            end
            STEP_END: begin
                if (t_q == LastStep) begin
                    state_d = DONE;
                end else begin
                    t_d     = t_q + STEP_BITS'(1);
                    state_d = SCAN;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d     = (state_d != IDLE);
        ts_done_d  = (state_d == STEP_END);
        enc_done_d = (state_d == DONE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            t_q        <= '0;
            new_img_q  <= 1'b0;
            busy_q     <= 1'b0;
            ts_done_q  <= 1'b0;
            enc_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            t_q        <= t_d;
            new_img_q  <= NEW_IMAGE;
            busy_q     <= busy_d;
            ts_done_q  <= ts_done_d;
            enc_done_q <= enc_done_d;
        end
    end

    assign SPIKE_VALID   = (state_q == SCAN) & carry;
    assign SPIKE_ADDR    = idx_q;
    assign TIMESTEP_DONE = ts_done_q;
    assign ENCODE_DONE   = enc_done_q;
    assign BUSY          = busy_q;

endmodule

// File: tb/tb_image_spike_encoder.sv
// Scoreboard bench: a per-pixel accumulator model predicts every spike and step; a monitor checks.
module tb_image_spike_encoder;

`ifdef SPIKE_ENC_PHASE_INIT_EN
    localparam int AccInit = 128;
`else
    localparam int AccInit = 0;
`endif
    localparam int EncodeCycles = 16 * 257 + 1;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic [255:0][7:0] IMAGE = '0;
    logic             NEW_IMAGE = 1'b0;
    logic             SPIKE_READY = 1'b1;
    logic             SPIKE_VALID;
    logic [7:0]       SPIKE_ADDR;
    logic             TIMESTEP_DONE;
    logic             ENCODE_DONE;
    logic             BUSY;

    image_spike_encoder dut (
        .CLK           (CLK),
        .RST           (RST),
        .IMAGE         (IMAGE),
        .NEW_IMAGE     (NEW_IMAGE),
        .SPIKE_VALID   (SPIKE_VALID),
        .SPIKE_READY   (SPIKE_READY),
        .SPIKE_ADDR    (SPIKE_ADDR),
        .TIMESTEP_DONE (TIMESTEP_DONE),
        .ENCODE_DONE   (ENCODE_DONE),
        .BUSY          (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int addr;
        int t;
    } spk_t;

    spk_t exp_q[$];
    spk_t e_pop;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    int n_checks = 0, n_pass = 0, n_timeout = 0;
    int ts_total = 0, stall_total = 0, done_total = 0;
    int ts_base = 0, stall_base = 0, done_base = 0, start_cyc = 0;
    int ready_mode = 0, bp_req = 0, bp_served = 0;

    logic              prev_stall = 1'b0;
    logic [7:0]        prev_addr = '0;
    logic [255:0][7:0] img_v;

    function automatic void check(string name, int act, int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endfunction

    // Monitor: all comparisons happen here, on the falling edge.
    always @(negedge CLK) begin
        if (RST) begin
            check("rst_valid", int'(SPIKE_VALID), 0);
            check("rst_busy", int'(BUSY), 0);
            check("rst_timestep_done", int'(TIMESTEP_DONE), 0);
            check("rst_encode_done", int'(ENCODE_DONE), 0);
            check("rst_addr", int'(SPIKE_ADDR), 0);
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", int'(SPIKE_VALID), 1);
                check("hold_addr", int'(SPIKE_ADDR), int'(prev_addr));
            end
            if (SPIKE_VALID && SPIKE_READY) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_spike_addr", int'(SPIKE_ADDR), -1);
                end else begin
                    e_pop = exp_q.pop_front();
                    check("spike_addr", int'(SPIKE_ADDR), e_pop.addr);
                    check("spike_step", ts_total - ts_base, e_pop.t);
                end
            end
            if (SPIKE_VALID && !SPIKE_READY) stall_total++;
            prev_stall = SPIKE_VALID && !SPIKE_READY;
            prev_addr  = SPIKE_ADDR;
            if (TIMESTEP_DONE) ts_total++;
            if (ENCODE_DONE) begin
                check("done_steps", ts_total - ts_base, 16);
                check("done_latency", cyc - start_cyc - (stall_total - stall_base), EncodeCycles);
                check("missing_spikes", exp_q.size(), 0);
                done_total++;
            end
        end
    end

    // Sole driver of SPIKE_READY; mode 3 stalls the next spike for exactly 10 cycles.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            case (ready_mode)
                0: SPIKE_READY = 1'b1;
                1: SPIKE_READY = ($urandom_range(0, 3) != 0);
                2: SPIKE_READY = 1'b0;
                default: begin
                    if (SPIKE_VALID && bp_served != bp_req) begin
                        SPIKE_READY = 1'b0;
                        bp_served++;
                        repeat (10) @(posedge CLK);
                        #1 SPIKE_READY = 1'b1;
                    end else begin
                        SPIKE_READY = 1'b1;
                    end
                end
            endcase
        end
    end

    task automatic start_encode(input logic [255:0][7:0] img);
        int acc[256];
        for (int p = 0; p < 256; p++) acc[p] = AccInit;
        for (int t = 0; t < 16; t++) begin
            for (int p = 0; p < 256; p++) begin
                acc[p] += int'(img[p]);
                if (acc[p] >= 256) begin
                    exp_q.push_back('{addr: p, t: t});
                    acc[p] -= 256;
                end
            end
        end
        IMAGE      = img;
        ts_base    = ts_total;
        stall_base = stall_total;
        done_base  = done_total;
        @(posedge CLK);
        #1 NEW_IMAGE = 1'b1;
        start_cyc = cyc + 1;
        repeat (3) @(posedge CLK);
        #1 NEW_IMAGE = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (done_total == done_base && k < 30000) begin
            @(posedge CLK);
            k++;
        end
        if (done_total == done_base) begin
            n_timeout++;
            $display("FAIL encode_timeout: no ENCODE_DONE after %0d cycles, expected one", k);
        end
        repeat (2) @(posedge CLK);
    endtask

    task automatic random_image();
        for (int p = 0; p < 256; p++) img_v[p] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;

        img_v = '0;
        start_encode(img_v);
        wait_done();

        img_v = '0;
        img_v[37] = 8'd255;
        start_encode(img_v);
        wait_done();

        img_v = '0;
        img_v[5]   = 8'd128;
        img_v[200] = 8'd64;
        start_encode(img_v);
        wait_done();

        img_v = '0;
        img_v[9] = 8'd8;
        start_encode(img_v);
        wait_done();

        // Backpressure on the first spike of a sparse image.
        img_v = '0;
        img_v[5]   = 8'd128;
        img_v[200] = 8'd64;
        ready_mode = 3;
        bp_req++;
        start_encode(img_v);
        wait_done();

        ready_mode = 1;
        for (int n = 0; n < 2; n++) begin
            random_image();
            start_encode(img_v);
            wait_done();
        end
        ready_mode = 0;

        // Re-trigger and image change mid-encode must not disturb the run.
        random_image();
        start_encode(img_v);
        repeat (600) @(posedge CLK);
        #1 NEW_IMAGE = 1'b1;
        random_image();
        IMAGE = img_v;
        repeat (4) @(posedge CLK);
        #1 NEW_IMAGE = 1'b0;
        wait_done();

        // Reset while a spike is stalled in timestep 1, then a clean encode.
        for (int p = 0; p < 256; p++) img_v[p] = 8'd255;
        start_encode(img_v);
        repeat (300) @(posedge CLK);
        #1 ready_mode = 2;
        repeat (4) @(posedge CLK);
        #2 RST = 1'b1;
        repeat (3) @(posedge CLK);
        exp_q.delete();
        #1 RST = 1'b0;
        ready_mode = 0;
        repeat (2) @(posedge CLK);
        random_image();
        start_encode(img_v);
        wait_done();

        $display("%0d/%0d checks passed", n_pass, n_checks + n_timeout);
        $finish;
    end

endmodule
